// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN geometry defaults, derived widths and window reader FSM states
package cnn_pkg;
    localparam int INPUT_SIZE      = 34;
    localparam int CNN_FILTER_SIZE = 7;
    localparam int CNN_STRIDE      = 2;
    localparam int CNN_NUM_FILTERS = 8;
    localparam int DATA_W          = 32;

    function automatic int calc_out(input int n, input int f, input int s);
        return (n - f) / s + 1;
    endfunction

    // $clog2(1) is 0, but every counter and port still needs at least one bit
    function automatic int width_of(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    function automatic int addr_width(input int n);
        return width_of(n * n);
    endfunction

    localparam int OUT    = calc_out(INPUT_SIZE, CNN_FILTER_SIZE, CNN_STRIDE);
    localparam int ADDR_W = addr_width(INPUT_SIZE);
    localparam int OUT_W  = width_of(OUT);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_FIN     = 3'd4
    } rd_state_t;
endpackage

// File: rtl/conv_window_reader_if.sv
// rtl/conv_window_reader_if.sv - image buffer read port and window element stream; CONV_WIN_COORD_EN adds window coordinates
interface conv_window_reader_if #(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int ADDR_W = cnn_pkg::ADDR_W
`ifdef CONV_WIN_COORD_EN
    ,
    parameter int OUT_W  = cnn_pkg::OUT_W
`endif
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] pix_data;
    logic              pix_first;
    logic              pix_last;
`ifdef CONV_WIN_COORD_EN
    logic [OUT_W-1:0]  win_row;
    logic [OUT_W-1:0]  win_col;

    modport master (
        output rd_en, rd_addr, pix_valid, pix_data, pix_first, pix_last, win_row, win_col,
        input  rd_data, pix_ready
    );
    modport slave (
        input  rd_en, rd_addr, pix_valid, pix_data, pix_first, pix_last, win_row, win_col,
        output rd_data, pix_ready
    );
`else
    modport master (
        output rd_en, rd_addr, pix_valid, pix_data, pix_first, pix_last,
        input  rd_data, pix_ready
    );
    modport slave (
        input  rd_en, rd_addr, pix_valid, pix_data, pix_first, pix_last,
        output rd_data, pix_ready
    );
`endif
endinterface

// File: rtl/conv_window_reader_addr_gen.sv
// rtl/conv_window_reader_addr_gen.sv - conv_win_addr_gen: window index counters and adder-only row-major address walk
// CONV_WIN_COORD_EN exposes the output row/column counters.
module conv_win_addr_gen
    import cnn_pkg::*;
#(
    parameter int  INPUT_SIZE      = cnn_pkg::INPUT_SIZE,
    parameter int  CNN_FILTER_SIZE = cnn_pkg::CNN_FILTER_SIZE,
    parameter int  CNN_STRIDE      = cnn_pkg::CNN_STRIDE,
    localparam int ADDR_W          = addr_width(INPUT_SIZE),
    localparam int OUT_N           = calc_out(INPUT_SIZE, CNN_FILTER_SIZE, CNN_STRIDE),
    localparam int OUT_W           = width_of(OUT_N)
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              clear_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              first_o,
    output logic              last_o,
`ifdef CONV_WIN_COORD_EN
    output logic [OUT_W-1:0]  orow_o,
    output logic [OUT_W-1:0]  ocol_o,
`endif
    output logic              final_o
);
    localparam int                K_W       = width_of(CNN_FILTER_SIZE);
    localparam logic [K_W-1:0]    K_MAX     = K_W'(CNN_FILTER_SIZE - 1);
    localparam logic [OUT_W-1:0]  O_MAX     = OUT_W'(OUT_N - 1);
    localparam logic [ADDR_W-1:0] KR_STEP   = ADDR_W'(INPUT_SIZE - (CNN_FILTER_SIZE - 1));
    localparam logic [ADDR_W-1:0] OCOL_STEP = ADDR_W'(CNN_STRIDE);
    localparam logic [ADDR_W-1:0] OROW_STEP = ADDR_W'(CNN_STRIDE * INPUT_SIZE);

    logic [K_W-1:0]    kr_q, kr_d, kc_q, kc_d;
    logic [OUT_W-1:0]  orow_q, orow_d, ocol_q, ocol_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d, win_base_q, win_base_d, addr_q, addr_d;

    // addr_q always points at element (kr,kc) of the current window; the bases
    // mark the top-left corner of the current output row and window.
    always_comb begin
        kr_d       = kr_q;
        kc_d       = kc_q;
        orow_d     = orow_q;
        ocol_d     = ocol_q;
        row_base_d = row_base_q;
        win_base_d = win_base_q;
        addr_d     = addr_q;
        if (clear_i) begin
            kr_d       = '0;
            kc_d       = '0;
            orow_d     = '0;
            ocol_d     = '0;
            row_base_d = '0;
            win_base_d = '0;
            addr_d     = '0;
        end else if (advance_i) begin
            if (kc_q != K_MAX) begin
                kc_d   = kc_q + K_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end else if (kr_q != K_MAX) begin
                kc_d   = '0;
                kr_d   = kr_q + K_W'(1);
                addr_d = addr_q + KR_STEP;
            end else begin
                kc_d = '0;
                kr_d = '0;
                if (ocol_q != O_MAX) begin
                    ocol_d     = ocol_q + OUT_W'(1);
                    win_base_d = win_base_q + OCOL_STEP;
                    addr_d     = win_base_d;
                end else if (orow_q != O_MAX) begin
                    ocol_d     = '0;
                    orow_d     = orow_q + OUT_W'(1);
                    row_base_d = row_base_q + OROW_STEP;
                    win_base_d = row_base_d;
                    addr_d     = row_base_d;
                end else begin
                    // Final element: wrap so the next pass starts at window (0,0)
                    ocol_d     = '0;
                    orow_d     = '0;
                    row_base_d = '0;
                    win_base_d = '0;
                    addr_d     = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            kr_q       <= '0;
            kc_q       <= '0;
            orow_q     <= '0;
            ocol_q     <= '0;
            row_base_q <= '0;
            win_base_q <= '0;
            addr_q     <= '0;
        end else begin
            kr_q       <= kr_d;
            kc_q       <= kc_d;
            orow_q     <= orow_d;
            ocol_q     <= ocol_d;
            row_base_q <= row_base_d;
            win_base_q <= win_base_d;
            addr_q     <= addr_d;
        end
    end

    assign rd_addr_o = addr_q;
    assign first_o   = (kr_q == '0) && (kc_q == '0);
    assign last_o    = (kr_q == K_MAX) && (kc_q == K_MAX);
    assign final_o   = last_o && (orow_q == O_MAX) && (ocol_q == O_MAX);
`ifdef CONV_WIN_COORD_EN
    assign orow_o    = orow_q;
    assign ocol_o    = ocol_q;
`endif
endmodule

// File: rtl/conv_window_reader.sv
// rtl/conv_window_reader.sv - streams every convolution receptive field of a buffered image, one element per handshake
// CONV_WIN_COORD_EN adds registered win_row/win_col outputs.
module conv_window_reader
    import cnn_pkg::*;
#(
    parameter int  INPUT_SIZE      = cnn_pkg::INPUT_SIZE,
    parameter int  CNN_FILTER_SIZE = cnn_pkg::CNN_FILTER_SIZE,
    parameter int  CNN_STRIDE      = cnn_pkg::CNN_STRIDE,
    parameter int  DATA_W          = cnn_pkg::DATA_W,
    localparam int ADDR_W          = addr_width(INPUT_SIZE),
    localparam int OUT_N           = calc_out(INPUT_SIZE, CNN_FILTER_SIZE, CNN_STRIDE),
    localparam int OUT_W           = width_of(OUT_N)
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    conv_window_reader_if.master bus
);
    rd_state_t         state_q;
    logic              busy_q, done_q, rd_en_q;
    logic              pix_valid_q, pix_first_q, pix_last_q;
    logic [DATA_W-1:0] pix_data_q;

    logic              handshake, start_accept;
    logic [ADDR_W-1:0] gen_addr;
    logic              gen_first, gen_last, gen_final;
`ifdef CONV_WIN_COORD_EN
    logic [OUT_W-1:0]  gen_orow, gen_ocol;
    logic [OUT_W-1:0]  win_row_q, win_col_q;
`endif

    assign start_accept = (state_q == ST_IDLE) && start_i;
    assign handshake    = (state_q == ST_PRESENT) && pix_valid_q && bus.pix_ready;

    conv_win_addr_gen #(
        .INPUT_SIZE      (INPUT_SIZE),
        .CNN_FILTER_SIZE (CNN_FILTER_SIZE),
        .CNN_STRIDE      (CNN_STRIDE)
    ) u_addr_gen (
        .clk       (clk),
        .rstb      (rstb),
        .clear_i   (start_accept),
        .advance_i (handshake),
        .rd_addr_o (gen_addr),
        .first_o   (gen_first),
        .last_o    (gen_last),
`ifdef CONV_WIN_COORD_EN
        .orow_o    (gen_orow),
        .ocol_o    (gen_ocol),
`endif
        .final_o   (gen_final)
    );

    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_first_q <= 1'b0;
            pix_last_q  <= 1'b0;
`ifdef CONV_WIN_COORD_EN
            win_row_q   <= '0;
            win_col_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_FETCH;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_LOAD;
                    rd_en_q <= 1'b0;
                end
                // Buffer data arrives this cycle; the index flags still describe it
                ST_LOAD: begin
                    state_q     <= ST_PRESENT;
                    pix_valid_q <= 1'b1;
                    pix_data_q  <= bus.rd_data;
                    pix_first_q <= gen_first;
                    pix_last_q  <= gen_last;
`ifdef CONV_WIN_COORD_EN
                    win_row_q   <= gen_orow;
                    win_col_q   <= gen_ocol;
`endif
                end
                ST_PRESENT: begin
                    if (handshake) begin
                        pix_valid_q <= 1'b0;
                        if (gen_final) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_FETCH;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = gen_addr;
    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_data  = pix_data_q;
    assign bus.pix_first = pix_first_q;
    assign bus.pix_last  = pix_last_q;
`ifdef CONV_WIN_COORD_EN
    assign bus.win_row   = win_row_q;
    assign bus.win_col   = win_col_q;
`endif
endmodule

// File: tb/tb_conv_window_reader.sv
// tb/tb_conv_window_reader.sv - directed checks of the window reader stream, backpressure, start filtering and reset abort
// CONV_WIN_COORD_EN enables the window coordinate checks.
module tb_conv_window_reader;
    import cnn_pkg::*;

    localparam int WIN_ELEMS = CNN_FILTER_SIZE * CNN_FILTER_SIZE;
    localparam int TOTAL     = OUT * OUT * WIN_ELEMS;

    logic clk   = 1'b0;
    logic rstb  = 1'b1;
    logic start = 1'b0;
    logic busy, done;
    int   tests_run    = 0;
    int   tests_failed = 0;

    conv_window_reader_if rif ();

    conv_window_reader dut (
        .clk     (clk),
        .rstb    (rstb),
        .start_i (start),
        .busy_o  (busy),
        .done_o  (done),
        .bus     (rif)
    );

    always #5 clk = ~clk;

    // Image buffer preloaded with data = address, one-cycle read latency
    always @(posedge clk) if (rif.rd_en) rif.rd_data <= 32'(rif.rd_addr);

    function automatic int exp_addr(input int n);
        int w, e, orow, ocol, kr, kc;
        w    = n / WIN_ELEMS;
        e    = n % WIN_ELEMS;
        orow = w / OUT;
        ocol = w % OUT;
        kr   = e / CNN_FILTER_SIZE;
        kc   = e % CNN_FILTER_SIZE;
        return (orow * CNN_STRIDE + kr) * INPUT_SIZE + ocol * CNN_STRIDE + kc;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstb = 1'b1;
        start = 1'b1;
        rif.pix_ready = 1'b1;
        repeat (3) tick;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
        tests_run++; if (rif.rd_en !== 1'b0 || rif.rd_addr !== '0) begin tests_failed++; $display("FAIL reset_rd: got en=%b addr=%0d want 0/0", rif.rd_en, rif.rd_addr); end
        tests_run++; if (rif.pix_valid !== 1'b0 || rif.pix_data !== 32'd0) begin tests_failed++; $display("FAIL reset_pix: got valid=%b data=%0d want 0/0", rif.pix_valid, rif.pix_data); end
        tests_run++; if (rif.pix_first !== 1'b0 || rif.pix_last !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: got first=%b last=%b want 0/0", rif.pix_first, rif.pix_last); end
        start = 1'b0;
        rstb = 1'b0;
        repeat (2) tick;
        tests_run++; if (busy !== 1'b0 || rif.rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wins_start: got busy=%b rd_en=%b want 0/0", busy, rif.rd_en); end
    endtask

    task automatic test_full_pass;
        int cyc = 1, n = 0, first_valid = -1, last_hs = -1, done_cyc = -1, done_cnt = 0;
        int data_err = 0, flag_err = 0, gap_err = 0, busy_err = 0, post_err = 0;
        int d0 = -1, d48 = -1, d49 = -1, d9555 = -1, d9603 = -1;
        logic f0 = 1'b0, l48 = 1'b0, f49 = 1'b0, f9555 = 1'b0, l9603 = 1'b0;
        bit mid_sent = 0, fin_sent = 0;
`ifdef CONV_WIN_COORD_EN
        int r0 = -1, c0 = -1, r49 = -1, c49 = -1, rl = -1, cl = -1;
`endif
        rif.pix_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        while (cyc < 40000 && !(done_cyc >= 0 && cyc > done_cyc + 5)) begin
            start = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                if (!fin_sent) begin start = 1'b1; fin_sent = 1; end
            end
            if (done_cyc < 0 && busy !== 1'b1) busy_err++;
            if (done_cyc >= 0 && cyc > done_cyc && (busy !== 1'b0 || rif.pix_valid !== 1'b0 || rif.rd_en !== 1'b0)) post_err++;
            if (rif.pix_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (rif.pix_valid === 1'b1 && rif.pix_ready === 1'b1) begin
                if (rif.pix_data !== 32'(exp_addr(n))) data_err++;
                if (rif.pix_first !== (n % WIN_ELEMS == 0) || rif.pix_last !== (n % WIN_ELEMS == WIN_ELEMS - 1)) flag_err++;
                if (last_hs >= 0 && cyc - last_hs != 3) gap_err++;
                case (n)
                    0:    begin d0 = int'(rif.pix_data); f0 = rif.pix_first; end
                    48:   begin d48 = int'(rif.pix_data); l48 = rif.pix_last; end
                    49:   begin d49 = int'(rif.pix_data); f49 = rif.pix_first; end
                    9555: begin d9555 = int'(rif.pix_data); f9555 = rif.pix_first; end
                    9603: begin d9603 = int'(rif.pix_data); l9603 = rif.pix_last; end
                    default: ;
                endcase
`ifdef CONV_WIN_COORD_EN
                if (n == 0)  begin r0 = int'(rif.win_row); c0 = int'(rif.win_col); end
                if (n == 49) begin r49 = int'(rif.win_row); c49 = int'(rif.win_col); end
                if (n == TOTAL - 1) begin rl = int'(rif.win_row); cl = int'(rif.win_col); end
`endif
                last_hs = cyc;
                n++;
            end
            if (n == 100 && !mid_sent) begin start = 1'b1; mid_sent = 1; end
            tick;
            cyc++;
        end
        start = 1'b0;
        tests_run++; if (first_valid != 3) begin tests_failed++; $display("FAIL first_valid_latency: got %0d want 3", first_valid); end
        tests_run++; if (n != TOTAL) begin tests_failed++; $display("FAIL handshake_count: got %0d want %0d", n, TOTAL); end
        tests_run++; if (done_cnt != 1 || done_cyc != last_hs + 1) begin tests_failed++; $display("FAIL done_pulse: got count=%0d at %0d want 1 at %0d", done_cnt, done_cyc, last_hs + 1); end
        tests_run++; if (data_err != 0) begin tests_failed++; $display("FAIL stream_data: got %0d bad elements want 0", data_err); end
        tests_run++; if (flag_err != 0) begin tests_failed++; $display("FAIL stream_flags: got %0d bad elements want 0", flag_err); end
        tests_run++; if (gap_err != 0) begin tests_failed++; $display("FAIL element_gap: got %0d gaps not 3 want 0", gap_err); end
        tests_run++; if (busy_err != 0) begin tests_failed++; $display("FAIL busy_continuous: got %0d low cycles want 0", busy_err); end
        tests_run++; if (post_err != 0) begin tests_failed++; $display("FAIL quiet_after_done: got %0d active cycles want 0", post_err); end
        tests_run++; if (d0 != 0 || f0 !== 1'b1) begin tests_failed++; $display("FAIL win0_first: got data=%0d first=%b want 0/1", d0, f0); end
        tests_run++; if (d48 != 210 || l48 !== 1'b1) begin tests_failed++; $display("FAIL win0_last: got data=%0d last=%b want 210/1", d48, l48); end
        tests_run++; if (d49 != 2 || f49 !== 1'b1) begin tests_failed++; $display("FAIL win01_first: got data=%0d first=%b want 2/1", d49, f49); end
        tests_run++; if (d9555 != 910 || f9555 !== 1'b1) begin tests_failed++; $display("FAIL win1313_first: got data=%0d first=%b want 910/1", d9555, f9555); end
        tests_run++; if (d9603 != 1120 || l9603 !== 1'b1) begin tests_failed++; $display("FAIL win1313_last: got data=%0d last=%b want 1120/1", d9603, l9603); end
`ifdef CONV_WIN_COORD_EN
        tests_run++; if (r0 != 0 || c0 != 0) begin tests_failed++; $display("FAIL coord_first: got %0d/%0d want 0/0", r0, c0); end
        tests_run++; if (r49 != 0 || c49 != 1) begin tests_failed++; $display("FAIL coord_elem49: got %0d/%0d want 0/1", r49, c49); end
        tests_run++; if (rl != 13 || cl != 13) begin tests_failed++; $display("FAIL coord_final: got %0d/%0d want 13/13", rl, cl); end
`endif
    endtask

    task automatic test_backpressure_abort;
        int cyc = 1, n = 0, data_err = 0, hold_err = 0, rd_err = 0, d4 = -1, post_err = 0;
        bit bp_seen = 0, rst_seen = 0;
        logic rst_valid = 1'b1, rst_busy = 1'b1, rst_done = 1'b1;
        rif.pix_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        while (cyc < 3000 && !rst_seen) begin
            if (rif.pix_valid === 1'b1 && n == 3 && !bp_seen) begin
                bp_seen = 1;
                rif.pix_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick;
                    cyc++;
                    if (rif.pix_valid !== 1'b1 || rif.pix_data !== 32'd3 || rif.pix_first !== 1'b0 || rif.pix_last !== 1'b0) hold_err++;
                    if (rif.rd_en !== 1'b0) rd_err++;
                end
                rif.pix_ready = 1'b1;
            end
            if (rif.pix_valid === 1'b1 && n == 500) begin
                rst_seen = 1;
                rstb = 1'b1;
                tick;
                rst_valid = rif.pix_valid;
                rst_busy  = busy;
                rst_done  = done;
                rstb = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    tick;
                    if (done !== 1'b0 || busy !== 1'b0 || rif.pix_valid !== 1'b0) post_err++;
                end
            end else begin
                if (rif.pix_valid === 1'b1 && rif.pix_ready === 1'b1) begin
                    if (rif.pix_data !== 32'(exp_addr(n))) data_err++;
                    if (n == 4) d4 = int'(rif.pix_data);
                    n++;
                end
                tick;
                cyc++;
            end
        end
        tests_run++; if (!bp_seen || hold_err != 0) begin tests_failed++; $display("FAIL bp_hold: got seen=%0d bad=%0d want 1/0", bp_seen, hold_err); end
        tests_run++; if (rd_err != 0) begin tests_failed++; $display("FAIL bp_no_read: got %0d rd_en cycles want 0", rd_err); end
        tests_run++; if (d4 != 4) begin tests_failed++; $display("FAIL bp_resume: got %0d want 4", d4); end
        tests_run++; if (data_err != 0) begin tests_failed++; $display("FAIL bp_stream_data: got %0d bad elements want 0", data_err); end
        tests_run++; if (!rst_seen || rst_valid !== 1'b0 || rst_busy !== 1'b0 || rst_done !== 1'b0) begin tests_failed++; $display("FAIL abort_next_cycle: got seen=%0d valid=%b busy=%b done=%b want 1/0/0/0", rst_seen, rst_valid, rst_busy, rst_done); end
        tests_run++; if (post_err != 0) begin tests_failed++; $display("FAIL abort_quiet: got %0d active cycles want 0", post_err); end
    endtask

    task automatic test_restart;
        int cyc = 1;
        rif.pix_ready = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        while (rif.pix_valid !== 1'b1 && cyc < 20) begin
            tick;
            cyc++;
        end
        tests_run++; if (cyc != 3) begin tests_failed++; $display("FAIL restart_latency: got %0d want 3", cyc); end
        tests_run++; if (rif.pix_data !== 32'd0 || rif.pix_first !== 1'b1 || rif.pix_last !== 1'b0) begin tests_failed++; $display("FAIL restart_first: got data=%0d first=%b last=%b want 0/1/0", rif.pix_data, rif.pix_first, rif.pix_last); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL restart_busy: got %b want 1", busy); end
        rstb = 1'b1;
        tick;
        rstb = 1'b0;
        tick;
    endtask

    initial begin
        rif.pix_ready = 1'b0;
        test_reset;
        test_full_pass;
        test_backpressure_abort;
        test_restart;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
